// File: rtl/audio_ctrl_pkg.sv
// Shared sizes, saturation limits and stage record for the audio stream controller.
// Also hosts the saturating noise adder used on both channels.
package audio_ctrl_pkg;

    localparam int DEPTH    = 4;
    localparam int SAMPLE_W = 24;
    localparam int NOISE_W  = 16;
    localparam int LVL_W    = $clog2(DEPTH + 1);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int PAIR_W   = 2 * SAMPLE_W;

    localparam logic [LVL_W-1:0]    LVL_FULL = LVL_W'(DEPTH);
    localparam logic [SAMPLE_W-1:0] MAX_S    = 24'h7FFFFF;
    localparam logic [SAMPLE_W-1:0] MIN_S    = 24'h800000;

    // Bit order matches key_n: [0] mute, [1] swap, [2] add noise.
    typedef struct packed {
        logic add_noise;
        logic swap;
        logic mute;
    } fx_t;

    typedef struct packed {
        fx_t                 fx;
        logic [NOISE_W-1:0]  noise;
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stage_t;

    function automatic logic [SAMPLE_W-1:0] sat_add(input logic [SAMPLE_W-1:0] s,
                                                    input logic [NOISE_W-1:0]  n);
        logic [SAMPLE_W:0] sum;
        sum = {s[SAMPLE_W-1], s} + {{(SAMPLE_W-NOISE_W+1){n[NOISE_W-1]}}, n};
        // Top two bits disagree only on signed overflow; the top bit gives direction.
        if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
            return sum[SAMPLE_W] ? MIN_S : MAX_S;
        end
        return sum[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// DEPTH-entry FIFO of stereo pairs; head visible combinationally, level updated next cycle.
// Push when full and pop when empty are ignored; simultaneous push/pop keeps level.
module sample_fifo
    import audio_ctrl_pkg::*;
#(
    parameter int W = PAIR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic [LVL_W-1:0] level
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && (level_q != LVL_FULL);
        do_pop   = pop && (level_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign level    = level_q;

endmodule

// File: rtl/audio_stream_ctrl.sv
// Codec ADC->DAC sample pump with key effects (swap, mute-left, saturating noise); read-to-write 2 cycles min.
// Reads stop once buffer + stage hold DEPTH samples; write_ready low simply holds the buffer.
module audio_stream_ctrl
    import audio_ctrl_pkg::*;
(
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                read_ready,
    input  logic [SAMPLE_W-1:0] readdata_left,
    input  logic [SAMPLE_W-1:0] readdata_right,
    input  logic                write_ready,
    input  logic [2:0]          key_n,
    input  logic [NOISE_W-1:0]  noise,
    output logic                read,
    output logic                write,
    output logic [SAMPLE_W-1:0] writedata_left,
    output logic [SAMPLE_W-1:0] writedata_right,
    output logic [LVL_W-1:0]    fifo_level,
    output logic [15:0]         sample_cnt,
    output logic [15:0]         stall_cnt
);

    logic [2:0]          key_meta_q, key_meta_d;
    logic [2:0]          key_sync_q, key_sync_d;
    stage_t              stage_q, stage_d;
    logic                stage_vld_q, stage_vld_d;
    logic [15:0]         sample_cnt_q, sample_cnt_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;

    fx_t                 fx;
    logic [SAMPLE_W-1:0] proc_l, proc_r;
    logic [LVL_W-1:0]    level_w, occ;
    logic [PAIR_W-1:0]   head_w;

    sample_fifo #(.W(PAIR_W)) u_fifo (
        .clk      (CLOCK_50),
        .rst_n    (reset_n),
        .push     (stage_vld_q),
        .push_dat ({proc_l, proc_r}),
        .pop      (write),
        .head_dat (head_w),
        .level    (level_w)
    );

    always_comb begin
        // The staged sample is counted so a read is never accepted without a free slot for it.
        occ   = level_w + LVL_W'(stage_vld_q);
        read  = reset_n && read_ready && (occ < LVL_FULL);
        write = reset_n && write_ready && (level_w != '0);

        key_meta_d  = key_n;
        key_sync_d  = key_meta_q;
        stage_d     = stage_q;
        stage_vld_d = read;
        if (read) begin
            stage_d.fx    = fx_t'(~key_sync_q);
            stage_d.noise = noise;
            stage_d.left  = readdata_left;
            stage_d.right = readdata_right;
        end

        fx     = stage_q.fx;
        proc_l = fx.swap ? stage_q.right : stage_q.left;
        proc_r = fx.swap ? stage_q.left  : stage_q.right;
        if (fx.mute) begin
            proc_l = '0;
        end
        if (fx.add_noise) begin
            proc_l = sat_add(proc_l, stage_q.noise);
            proc_r = sat_add(proc_r, stage_q.noise);
        end

        sample_cnt_d = write ? sample_cnt_q + 16'd1 : sample_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (read_ready && !read && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Synchronizers reset to the released level so no effect is active out of reset.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_meta_q   <= 3'b111;
            key_sync_q   <= 3'b111;
            stage_q      <= '0;
            stage_vld_q  <= 1'b0;
            sample_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            key_meta_q   <= key_meta_d;
            key_sync_q   <= key_sync_d;
            stage_q      <= stage_d;
            stage_vld_q  <= stage_vld_d;
            sample_cnt_q <= sample_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign writedata_left  = (level_w != '0) ? head_w[PAIR_W-1:SAMPLE_W] : '0;
    assign writedata_right = (level_w != '0) ? head_w[SAMPLE_W-1:0]      : '0;
    assign fifo_level      = level_w;
    assign sample_cnt      = sample_cnt_q;
    assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Bench for audio_stream_ctrl: effect vectors from a table, plus backpressure, level and reset sequences.
// A negedge monitor scoreboards every written pair against a model queued on each read.
module tb_audio_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset_n, read_ready, write_ready;
    logic [23:0] readdata_left, readdata_right;
    logic [2:0]  key_n;
    logic [15:0] noise;
    logic        read, write;
    logic [23:0] writedata_left, writedata_right;
    logic [2:0]  fifo_level;
    logic [15:0] sample_cnt, stall_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_reads  = 0;
    int          n_writes = 0;
    int          last_rd_cyc = 0;
    int          last_wr_cyc = 0;
    logic [23:0] last_wr_l, last_wr_r;
    logic [47:0] exp_q[$];
    logic [23:0] src_l [16];
    logic [23:0] src_r [16];
    int          src_n = 0;
    int          src_idx = 0;

    typedef struct {
        logic [2:0]  key_n;
        logic [15:0] noise;
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
        string       name;
    } vec_t;
    vec_t vecs [8];

    audio_stream_ctrl dut (
        .CLOCK_50        (clk),
        .reset_n         (reset_n),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .write_ready     (write_ready),
        .key_n           (key_n),
        .noise           (noise),
        .read            (read),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .fifo_level      (fifo_level),
        .sample_cnt      (sample_cnt),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [23:0] sat24(input logic [23:0] s, input logic [15:0] n);
        int v;
        v = $signed(s) + $signed(n);
        if (v > 8388607)  v = 8388607;
        if (v < -8388608) v = -8388608;
        return v[23:0];
    endfunction

    function automatic logic [47:0] model(input logic [23:0] l, input logic [23:0] r,
                                          input logic [2:0] kn, input logic [15:0] nz);
        logic [23:0] a, b;
        a = kn[1] ? l : r;
        b = kn[1] ? r : l;
        if (!kn[0]) a = 24'h0;
        if (!kn[2]) begin
            a = sat24(a, nz);
            b = sat24(b, nz);
        end
        return {a, b};
    endfunction

    always @(negedge clk) begin
        logic [47:0] e;
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (write) begin
                n_writes++;
                last_wr_cyc = cyc;
                last_wr_l   = writedata_left;
                last_wr_r   = writedata_right;
                chk("sb_write_expected", {31'h0, exp_q.size() != 0}, 32'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_left",  {8'h0, writedata_left},  {8'h0, e[47:24]});
                    chk("sb_right", {8'h0, writedata_right}, {8'h0, e[23:0]});
                end
            end
            if (read) begin
                n_reads++;
                last_rd_cyc = cyc;
                exp_q.push_back(model(readdata_left, readdata_right, key_n, noise));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_src();
        read_ready     = (src_idx < src_n);
        readdata_left  = src_l[src_idx % 16];
        readdata_right = src_r[src_idx % 16];
    endtask

    task automatic load_src(input int n, input logic [23:0] base);
        for (int i = 0; i < 16; i++) begin
            src_l[i] = base + 24'(i * 'h111);
            src_r[i] = ~(base + 24'(i * 'h0F0F));
        end
        src_n   = n;
        src_idx = 0;
        drive_src();
    endtask

    task automatic run_src(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (read) src_idx++;
            tick();
            drive_src();
        end
    endtask

    initial begin
        int          base_w, base_r;
        logic [15:0] s0, s1;

        vecs[0] = '{3'b111, 16'h0000, 24'h000123, 24'hFFFF00, 24'h000123, 24'hFFFF00, "pass"};
        vecs[1] = '{3'b100, 16'h0000, 24'h000010, 24'h000020, 24'h000000, 24'h000010, "swap_mute"};
        vecs[2] = '{3'b011, 16'h7FFF, 24'h7FFFF0, 24'h000000, 24'h7FFFFF, 24'h007FFF, "sat_pos"};
        vecs[3] = '{3'b011, 16'h8000, 24'h800005, 24'h000100, 24'h800000, 24'hFF8100, "sat_neg"};
        vecs[4] = '{3'b101, 16'h0000, 24'h000001, 24'h000002, 24'h000002, 24'h000001, "swap"};
        vecs[5] = '{3'b110, 16'h0000, 24'h123456, 24'h654321, 24'h000000, 24'h654321, "mute"};
        vecs[6] = '{3'b011, 16'h0010, 24'h000005, 24'hFFFFFF, 24'h000015, 24'h00000F, "noise"};
        vecs[7] = '{3'b000, 16'hFFFF, 24'h000001, 24'h000000, 24'hFFFFFF, 24'h000000, "all_fx"};

        reset_n = 1'b0; read_ready = 1'b1; write_ready = 1'b1; key_n = 3'b111; noise = '0;
        readdata_left = 24'h00ABCD; readdata_right = 24'h00DCBA;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_read", {31'h0, read}, 32'h0);
        chk("rst_write", {31'h0, write}, 32'h0);
        chk("rst_wdata_l", {8'h0, writedata_left}, 32'h0);
        chk("rst_level", {29'h0, fifo_level}, 32'h0);
        chk("rst_sample_cnt", {16'h0, sample_cnt}, 32'h0);
        chk("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
        tick();
        reset_n = 1'b1; read_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            key_n = vecs[i].key_n; noise = vecs[i].noise;
            readdata_left = vecs[i].l; readdata_right = vecs[i].r;
            read_ready = 1'b0; write_ready = 1'b1;
            repeat (4) tick();
            base_w = n_writes;
            read_ready = 1'b1;
            @(negedge clk);
            chk({vecs[i].name, "_read"}, {31'h0, read}, 32'h1);
            tick();
            read_ready = 1'b0;
            for (int w = 0; w < 10 && n_writes == base_w; w++) tick();
            chk({vecs[i].name, "_written"}, n_writes - base_w, 1);
            chk({vecs[i].name, "_latency"}, last_wr_cyc - last_rd_cyc, 2);
            chk({vecs[i].name, "_left"},  {8'h0, last_wr_l}, {8'h0, vecs[i].exp_l});
            chk({vecs[i].name, "_right"}, {8'h0, last_wr_r}, {8'h0, vecs[i].exp_r});
            if (i == 0) begin
                @(negedge clk);
                chk("pass_sample_cnt", {16'h0, sample_cnt}, 32'h1);
                tick();
            end
        end

        // Backpressure: six samples offered into a stalled output.
        key_n = 3'b111; noise = '0; write_ready = 1'b0;
        repeat (4) tick();
        base_w = n_writes; base_r = n_reads;
        load_src(6, 24'h100000);
        run_src(12);
        @(negedge clk);
        chk("bp_reads", n_reads - base_r, 4);
        chk("bp_level", {29'h0, fifo_level}, 32'h4);
        chk("bp_no_write", {31'h0, write}, 32'h0);
        chk("bp_writes", n_writes - base_w, 0);
        s0 = stall_cnt;
        @(negedge clk);
        s1 = stall_cnt;
        chk("bp_stall_step1", {16'h0, 16'(s1 - s0)}, 32'h1);
        @(negedge clk);
        chk("bp_stall_step2", {16'h0, 16'(stall_cnt - s1)}, 32'h1);
        tick();
        force dut.stall_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.stall_cnt_q;
        @(negedge clk);
        chk("stall_sat_1", {16'h0, stall_cnt}, 32'hFFFF);
        @(negedge clk);
        chk("stall_sat_2", {16'h0, stall_cnt}, 32'hFFFF);
        tick();
        write_ready = 1'b1;
        run_src(20);
        @(negedge clk);
        chk("bp_all_reads", n_reads - base_r, 6);
        chk("bp_all_writes", n_writes - base_w, 6);
        chk("bp_drained", {29'h0, fifo_level}, 32'h0);
        tick();

        // Push and pop in the same cycle at level 2.
        write_ready = 1'b0;
        load_src(2, 24'h200000);
        run_src(6);
        @(negedge clk);
        chk("sim_pre_level", {29'h0, fifo_level}, 32'h2);
        tick();
        load_src(1, 24'h300000);
        @(negedge clk);
        chk("sim_read", {31'h0, read}, 32'h1);
        tick();
        read_ready = 1'b0; write_ready = 1'b1;
        @(negedge clk);
        chk("sim_level_before", {29'h0, fifo_level}, 32'h2);
        chk("sim_write", {31'h0, write}, 32'h1);
        tick();
        write_ready = 1'b0;
        @(negedge clk);
        chk("sim_level_after", {29'h0, fifo_level}, 32'h2);
        tick();
        write_ready = 1'b1;
        repeat (6) tick();

        // Reset while three samples are buffered.
        write_ready = 1'b0;
        load_src(3, 24'h400000);
        run_src(8);
        @(negedge clk);
        chk("mid_pre_level", {29'h0, fifo_level}, 32'h3);
        tick();
        reset_n = 1'b0;
        write_ready = 1'b1;
        load_src(4, 24'h500000);
        #1;
        chk("mid_rst_level", {29'h0, fifo_level}, 32'h0);
        chk("mid_rst_read", {31'h0, read}, 32'h0);
        chk("mid_rst_write", {31'h0, write}, 32'h0);
        chk("mid_rst_wdata_r", {8'h0, writedata_right}, 32'h0);
        tick();
        tick();
        base_w = n_writes; base_r = n_reads;
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_first_read", {31'h0, read}, 32'h1);
        if (read) src_idx++;
        tick();
        drive_src();
        run_src(12);
        @(negedge clk);
        chk("mid_reads", n_reads - base_r, 4);
        chk("mid_writes", n_writes - base_w, 4);
        chk("end_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_stream_ctrl.md
AUDIO_STREAM_CTRL -- requirements
Module: audio_stream_ctrl

Interface
REQ-001 SHALL have clock CLOCK_50, input, 1 bit: single clock for all logic.
REQ-002 SHALL have reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have read_ready, input, 1 bit: codec ADC FIFO holds a stereo sample; readdata valid while high.
REQ-004 SHALL have readdata_left and readdata_right, inputs, 24 bits each: signed ADC samples.
REQ-005 SHALL have write_ready, input, 1 bit: codec DAC FIFO can accept a stereo sample.
REQ-006 SHALL have key_n, input, 3 bits: raw active-low buttons; [0] mute left, [1] swap channels, [2] add noise.
REQ-007 SHALL have noise, input, 16 bits: signed noise word from the noise generator.
REQ-008 SHALL have read, output, 1 bit: pops one sample from the codec ADC FIFO.
REQ-009 SHALL have write, output, 1 bit: pushes writedata into the codec DAC FIFO.
REQ-010 SHALL have writedata_left and writedata_right, outputs, 24 bits each: processed samples.
REQ-011 SHALL have fifo_level, output, 3 bits: occupancy of the internal buffer, 0 to 4.
REQ-012 SHALL have sample_cnt, output, 16 bits: count of samples written, wrapping.
REQ-013 SHALL have stall_cnt, output, 16 bits: count of read-stall cycles, saturating at 0xFFFF.

Function
REQ-014 SHALL pass key_n through a 2-FF synchronizer; the effect flags are the inverted synchronized levels.
REQ-015 SHALL drive read = read_ready AND (fifo_level + stage_valid < 4), combinationally from registered state.
REQ-016 SHALL capture readdata, the effect flags and noise into a stage register at the end of any cycle with read=1; stage_valid=1 in the next cycle.
REQ-017 SHALL process the stage register in this order:
- swap L/R if swap is set;
- force the left channel to 0 if mute is set;
- add sign-extended noise to both channels if noise is set, saturating to 0x7FFFFF / 0x800000.
REQ-018 SHALL push the processed pair into a 4-entry FIFO at the end of the stage_valid cycle, giving a minimum read-to-write latency of 2 cycles.
REQ-019 SHALL drive write = write_ready AND fifo_level != 0, with writedata equal to the FIFO head and 0 when the FIFO is empty.
REQ-020 SHALL leave fifo_level unchanged on a simultaneous push and pop.
REQ-021 SHALL never push when full or pop when empty; REQ-015 guarantees no overflow.
REQ-022 SHALL increment stall_cnt each cycle with read_ready=1 and read=0, saturating.
REQ-023 SHALL increment sample_cnt on each write=1 cycle, wrapping 0xFFFF to 0.
REQ-024 SHALL hold the FIFO contents with no pop while write_ready=0, and SHALL never drop data internally.
REQ-025 SHALL sustain one sample per cycle when read_ready and write_ready are both continuously high.

Reset
REQ-026 SHALL, on reset_n low, immediately clear the FIFO, stage register, synchronizers, fifo_level, sample_cnt and stall_cnt.
REQ-027 SHALL hold read=0, write=0 and writedata=0 during reset.
REQ-028 SHALL, on reset asserted mid-operation, discard in-flight and buffered samples; the first read is allowed in the first cycle after deassertion.

Structure
REQ-029 SHALL take DEPTH=4, SAMPLE_W=24, NOISE_W=16 and the saturation limits MAX_S / MIN_S from shared package audio_ctrl_pkg.
REQ-030 SHALL implement the buffer as sub-module sample_fifo (48-bit entries, push/pop/level, async active-low reset); effects and FSM logic stay in audio_stream_ctrl.

Verification
REQ-031 Passthrough: keys released, read_ready=write_ready=1, L=0x000123, R=0xFFFF00 -> write 2 cycles after read with identical data; sample_cnt=1.
REQ-032 Effects: swap+mute, L=0x000010, R=0x000020 -> writedata_left=0, writedata_right=0x000010.
REQ-033 Saturation: noise key, noise=0x7FFF, L=0x7FFFF0 -> writedata_left=0x7FFFFF; noise=0x8000, L=0x800005 -> 0x800000.
REQ-034 Backpressure: write_ready=0 with 6 samples offered -> exactly 4 reads, fifo_level=4, stall_cnt rises every cycle after; when write_ready=1, 4 writes in order and reads resume.
REQ-035 Simultaneous push/pop at level 2 -> level stays 2; stall_cnt forced to 0xFFFF holds at 0xFFFF.
REQ-036 Reset mid-stream at level 3 -> level=0, read=write=0 immediately; after release, no stale sample is ever written.
